program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: accepts instruction words over a valid/ready stream and writes them sequentially into the instruction store.
- Pads the unused tail of the store with FILL_WORD.
- Holds the CPU FSM in reset (cpu_hold) until the load completes.
- Lets a test harness or host stream a program in, instead of relying on a hard-coded memory image.

Parameters:
- OP_SIZE, 4, opcode field width
- ARG_SIZE, 3, argument field width
- ARG_NUM, 2, arguments per instruction; word width W = OP_SIZE + ARG_NUM*ARG_SIZE (10)
- DEPTH, 16, instruction store entries
- ADDR_W, 4, address width; DEPTH <= 2**ADDR_W
- FILL_WORD, 0, value written to unloaded entries (NOP/halt encoding)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE or DONE
- in_valid  in  1  in_data is valid
- in_data  in  W  instruction word
- in_last  in  1  marks the final word of the program
- in_ready  out  1  loader accepts a word this cycle
- mem_we  out  1  instruction store write enable
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  W  write data
- busy  out  1  high in LOAD/DRAIN/FILL
- load_done  out  1  high in DONE
- overflow  out  1  sticky: program exceeded DEPTH words
- word_count  out  ADDR_W+1  number of words written from the stream
- cpu_hold  out  1  keep the CPU FSM and registers in reset

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-load:
  - state=IDLE
  - mem_we=0, mem_addr=0, mem_wdata=0
  - in_ready=0, busy=0, load_done=0, overflow=0
  - word_count=0, cpu_hold=1
- States: IDLE, LOAD, DRAIN, FILL, DONE. All outputs are registered except in_ready, which decodes state (1 in LOAD and DRAIN).
- IDLE:
  - start -> LOAD; ptr=0, word_count=0, overflow=0, cpu_hold=1.
- LOAD:
  - Accept occurs when in_valid & in_ready.
  - On accept: next cycle mem_we=1, mem_addr=ptr, mem_wdata=in_data. Write latency is exactly 1 cycle. ptr and word_count increment.
  - Accept with in_last: if ptr+1 < DEPTH -> FILL, else -> DONE.
  - Accept without in_last at ptr=DEPTH-1: the word is written, then overflow=1 and the state moves to DRAIN.
  - No accept: mem_we=0.
- DRAIN:
  - in_ready=1; accepted words are discarded with no write.
  - Accepted word with in_last -> DONE.
  - word_count saturates at DEPTH.
- FILL:
  - in_ready=0.
  - One write per cycle: mem_we=1, mem_addr=ptr, mem_wdata=FILL_WORD.
  - ptr increments; the write at ptr=DEPTH-1 -> DONE.
  - Total FILL writes = DEPTH - word_count.
- DONE:
  - load_done=1, cpu_hold=0, mem_we=0.
  - start -> LOAD (reload); cpu_hold=1 again from the next cycle.
- start while busy is ignored.
- in_last in IDLE/DONE is ignored, since in_ready=0.
- Zero-length program is impossible; the first accepted word always counts.
- Stalls: in_valid may drop at any time in LOAD/DRAIN; no state change occurs and mem_we=0.
- mem_addr never exceeds DEPTH-1. mem_we=1 on at most one address per cycle.

Decomposition:
- Shared package `cpu_pkg`:
  - OP_SIZE, ARG_SIZE, ARG_NUM, derived INSTR_W.
  - Loader state enum.
  - NOP/halt opcode constant used as FILL_WORD.
- Single module. A separate `loader_wr_port` sub-module is natural for the registered write stage (ptr counter + mem_we/addr/wdata registers), shared by LOAD and FILL.

Test Plan:
1. Reset, start, stream 3 words 0x101, 0x2A5, 0x3FF (last on the third):
   - Writes addr 0..2 with those values, one cycle after each accept.
   - FILL writes FILL_WORD to addr 3..15.
   - load_done=1, word_count=3, cpu_hold falls after the addr-15 write.
2. Stream exactly 16 words, in_last on word 16:
   - No FILL cycles; DONE directly after the addr-15 write.
   - overflow=0, word_count=16.
3. Stream 18 words, in_last on word 18:
   - Addr 0..15 written; words 17–18 accepted but not written.
   - overflow=1, word_count=16, DONE.
4. Toggle in_valid 1,0,0,1,1 during LOAD:
   - mem_we pulses only one cycle after each accept.
   - Addresses stay contiguous, with no duplicate or skipped address.
5. Assert rst on the cycle of the 5th accept:
   - Next cycle state=IDLE, mem_we=0, word_count=0, cpu_hold=1.
   - A new start reloads from addr 0.
6. In DONE, pulse start, then stream 1 word (last):
   - cpu_hold returns to 1.
   - Addr 0 is rewritten; addr 1..15 are filled.
   - A start pulse during FILL has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, the NOP/halt fill word
// and the program loader state encoding.
package cpu_pkg;

  localparam int CPU_OP_SIZE  = 4;
  localparam int CPU_ARG_SIZE = 3;
  localparam int CPU_ARG_NUM  = 2;
  localparam int CPU_INSTR_W  = CPU_OP_SIZE + CPU_ARG_NUM * CPU_ARG_SIZE;

  // Opcode 0 with zero arguments doubles as NOP and halt for the CPU FSM.
  localparam logic [CPU_OP_SIZE-1:0] OP_NOP   = '0;
  localparam logic [CPU_INSTR_W-1:0] NOP_WORD = {OP_NOP, {(CPU_ARG_NUM * CPU_ARG_SIZE){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FILL,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/loader_wr_port.sv
// Registered write stage of the program loader: owns the store pointer and
// drives the instruction store one cycle after a write request.
module loader_wr_port
  import cpu_pkg::*;
#(
  parameter int W      = CPU_INSTR_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  output logic [ADDR_W-1:0] ptr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata
);

  // Address and data hold their last value between writes; only mem_we qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= ptr;
        mem_wdata <= wr_data;
        ptr       <= ptr + ADDR_W'(1);
      end else if (clear) begin
        ptr <= '0;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a program into the instruction store, pads the tail with the fill
// word and keeps the CPU held in reset until the store is complete.
module program_loader
  import cpu_pkg::*;
#(
  parameter int OP_SIZE  = CPU_OP_SIZE,
  parameter int ARG_SIZE = CPU_ARG_SIZE,
  parameter int ARG_NUM  = CPU_ARG_NUM,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  localparam int W       = OP_SIZE + ARG_NUM * ARG_SIZE,
  parameter logic [W-1:0] FILL_WORD = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_hold
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state;
  loader_state_t     state_next;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              wr_en;
  logic [W-1:0]      wr_data;
  logic              clear_ptr;
  logic              count_up;
  logic              set_ovf;

  assign in_ready = (state == ST_LOAD) || (state == ST_DRAIN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_data    = in_data;
    clear_ptr  = 1'b0;
    count_up   = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_LOAD;
          clear_ptr  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          count_up = 1'b1;
          if (in_last) begin
            state_next = (ptr == LAST_ADDR) ? ST_DONE : ST_FILL;
          end else if (ptr == LAST_ADDR) begin
            // Store is full but the program continues: swallow the rest.
            state_next = ST_DRAIN;
            set_ovf    = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && in_last) begin
          state_next = ST_DONE;
        end
      end
      ST_FILL: begin
        wr_en   = 1'b1;
        wr_data = FILL_WORD;
        if (ptr == LAST_ADDR) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status flags are registered from the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      load_done  <= 1'b0;
      cpu_hold   <= 1'b1;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      busy      <= (state_next == ST_LOAD) || (state_next == ST_DRAIN) || (state_next == ST_FILL);
      load_done <= (state_next == ST_DONE);
      cpu_hold  <= (state_next != ST_DONE);
      if (clear_ptr) begin
        overflow   <= 1'b0;
        word_count <= '0;
      end else begin
        if (set_ovf) begin
          overflow <= 1'b1;
        end
        if (count_up && (word_count != FULL_COUNT)) begin
          word_count <= word_count + (ADDR_W + 1)'(1);
        end
      end
    end
  end

  loader_wr_port #(
    .W      (W),
    .ADDR_W (ADDR_W)
  ) u_wr_port (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_ptr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ptr       (ptr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random programs and stalls are
// compared against the expected store image built from the program itself.
module tb_program_loader;

  localparam int W      = 10;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [W-1:0] FILL_WORD = '0;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_wdata;
  logic              busy;
  logic              load_done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic              cpu_hold;

  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;

  logic [W-1:0]      prog[$];
  bit                vpat[$];
  int                wr_cyc[$];
  int                acc_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [W-1:0]      wr_data[$];
  bit                hold_dropped;

  always #5 clk = ~clk;

  program_loader #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .FILL_WORD (FILL_WORD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .load_done  (load_done),
    .overflow   (overflow),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  // Records every store write and every stream handshake with its cycle number.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cyc.push_back(cycle);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      acc_cyc.push_back(cycle);
    end
    cycle = cycle + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic make_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(W'($urandom));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); acc_cyc.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream_prog(input int stall_pct, output bit timed_out);
    int idx = 0;
    int guard = 0;
    timed_out = 1'b0;
    while (idx < prog.size()) begin
      in_data = prog[idx];
      in_last = (idx == prog.size() - 1);
      if (vpat.size() > 0) in_valid = vpat.pop_front();
      else in_valid = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      if (cpu_hold !== 1'b1) hold_dropped = 1'b1;
      if (in_valid === 1'b1 && in_ready === 1'b1) idx++;
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        timed_out = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mem: got we=%b addr=%0h data=%0h, expected all 0", mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({in_ready, busy, load_done, overflow, cpu_hold} !== 5'b00001 || word_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got ready/busy/done/ovf/hold=%b%b%b%b%b count=%0d, expected 00001 count=0",
               in_ready, busy, load_done, overflow, cpu_hold, word_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_data = W'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL idle_ignores_stream: got ready=%b we=%b done=%b hold=%b, expected 0 0 0 1",
               in_ready, mem_we, load_done, cpu_hold);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_load(input string tag, input int stall_pct, input bit poke_start);
    int n;
    int nw;
    bit to;
    logic [W-1:0] exp_d;
    n  = prog.size();
    nw = (n < DEPTH) ? n : DEPTH;
    pulse_start();
    n_cmp++;
    if ({cpu_hold, busy, load_done, in_ready} !== 4'b1101) begin
      n_fail++;
      $display("[TB] FAIL %s start: got hold/busy/done/ready=%b%b%b%b, expected 1101",
               tag, cpu_hold, busy, load_done, in_ready);
    end
    hold_dropped = 1'b0;
    stream_prog(stall_pct, to);
    n_cmp++;
    if (to) begin
      n_fail++;
      $display("[TB] FAIL %s stream: got timeout, expected all %0d words accepted", tag, n);
    end
    if (poke_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(to);
    n_cmp++;
    if (to) begin
      n_fail++;
      $display("[TB] FAIL %s done_wait: got load_done=%b after 300 cycles, expected 1", tag, load_done);
    end
    n_cmp++;
    if (hold_dropped) begin
      n_fail++;
      $display("[TB] FAIL %s hold_during_load: got cpu_hold=0, expected 1", tag);
    end
    n_cmp++;
    if (wr_addr.size() != DEPTH) begin
      n_fail++;
      $display("[TB] FAIL %s write_count: got %0d, expected %0d", tag, wr_addr.size(), DEPTH);
    end
    for (int a = 0; a < DEPTH && a < wr_addr.size(); a++) begin
      exp_d = (a < n) ? prog[a] : FILL_WORD;
      n_cmp++;
      if (wr_addr[a] !== ADDR_W'(a) || wr_data[a] !== exp_d) begin
        n_fail++;
        $display("[TB] FAIL %s write[%0d]: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                 tag, a, wr_addr[a], wr_data[a], a, exp_d);
      end
    end
    n_cmp++;
    if (acc_cyc.size() != n) begin
      n_fail++;
      $display("[TB] FAIL %s accept_count: got %0d, expected %0d", tag, acc_cyc.size(), n);
    end
    for (int i = 0; i < nw && i < acc_cyc.size() && i < wr_cyc.size(); i++) begin
      n_cmp++;
      if (wr_cyc[i] != acc_cyc[i] + 1) begin
        n_fail++;
        $display("[TB] FAIL %s latency[%0d]: got write at cycle %0d, expected %0d", tag, i, wr_cyc[i], acc_cyc[i] + 1);
      end
    end
    for (int i = nw; i < wr_cyc.size(); i++) begin
      n_cmp++;
      if (wr_cyc[i] != wr_cyc[i-1] + 1) begin
        n_fail++;
        $display("[TB] FAIL %s fill_cadence[%0d]: got cycle %0d, expected %0d", tag, i, wr_cyc[i], wr_cyc[i-1] + 1);
      end
    end
    n_cmp++;
    if ({load_done, cpu_hold, busy, mem_we, in_ready} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL %s done_status: got done/hold/busy/we/ready=%b%b%b%b%b, expected 10000",
               tag, load_done, cpu_hold, busy, mem_we, in_ready);
    end
    n_cmp++;
    if (word_count !== (ADDR_W + 1)'(nw)) begin
      n_fail++;
      $display("[TB] FAIL %s word_count: got %0d, expected %0d", tag, word_count, nw);
    end
    n_cmp++;
    if (overflow !== (n > DEPTH)) begin
      n_fail++;
      $display("[TB] FAIL %s overflow: got %b, expected %b", tag, overflow, (n > DEPTH));
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (wr_addr.size() != DEPTH || load_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s quiescent: got writes=%0d done=%b, expected %0d and 1", tag, wr_addr.size(), load_done, DEPTH);
    end
  endtask

  task automatic test_short_program();
    prog.delete();
    prog.push_back(10'h101); prog.push_back(10'h2A5); prog.push_back(10'h3FF);
    test_load("short3", 0, 1'b0);
  endtask

  task automatic test_exact_fit();
    make_prog(DEPTH);
    test_load("exact16", 20, 1'b0);
  endtask

  task automatic test_overflow();
    make_prog(DEPTH + 2);
    test_load("over18", 20, 1'b0);
  endtask

  task automatic test_stalls();
    make_prog(5);
    vpat.delete();
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0);
    vpat.push_back(1'b1); vpat.push_back(1'b1);
    test_load("stall_pattern", 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    make_prog(10);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = prog[i];
      if (i == 4) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy, mem_we, load_done, cpu_hold} !== 5'b00001 || word_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL midload_reset: got ready/busy/we/done/hold=%b%b%b%b%b count=%0d, expected 00001 count=0",
               in_ready, busy, mem_we, load_done, cpu_hold, word_count);
    end
    n_cmp++;
    if (wr_addr.size() != 4) begin
      n_fail++;
      $display("[TB] FAIL midload_writes: got %0d writes, expected 4", wr_addr.size());
    end
    for (int a = 0; a < 4 && a < wr_addr.size(); a++) begin
      n_cmp++;
      if (wr_addr[a] !== ADDR_W'(a) || wr_data[a] !== prog[a]) begin
        n_fail++;
        $display("[TB] FAIL midload_write[%0d]: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                 a, wr_addr[a], wr_data[a], a, prog[a]);
      end
    end
    make_prog(3);
    test_load("reload_after_reset", 0, 1'b0);
  endtask

  task automatic test_reload_from_done();
    make_prog(1);
    test_load("reload_fill_start", 0, 1'b1);
  endtask

  task automatic test_random_programs();
    for (int k = 0; k < 4; k++) begin
      make_prog($urandom_range(1, DEPTH + 4));
      test_load($sformatf("random%0d", k), 25, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_short_program();
    test_exact_fit();
    test_overflow();
    test_stalls();
    test_reset_midload();
    test_reload_from_done();
    test_random_programs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
